// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage and IF/ID pipeline register. Holds the
//               PC, drives the instruction-memory address and captures the
//               fetched word plus PC+4 for decode. Consumes the hazard unit's
//               PC enable, IF/ID enable and taken-branch flush (PCSrc).
//               Optional macro FETCH_PERF_CNT_EN builds saturating stall and
//               flush counters; without it both counter ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        ifid_en,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [31:0] c_pc_step = 32'd4;

  // Debug-only fetch status, updated every edge from the sampled controls.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } status_t;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  status_t     r_status;
  status_t     w_status_next;

  // Wraps modulo 2^32 by construction; no carry is kept.
  assign w_pc_plus4    = r_pc + c_pc_step;
  // Redirect targets are forced word-aligned; the low bits are dropped.
  assign w_redirect_pc = {branch_target[31:2], 2'b00};
  assign imem_addr     = r_pc;

  // PC register: redirect beats the enable, otherwise advance or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (PCSrc) begin
      r_pc <= w_redirect_pc;
    end else if (pc_en) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register: flush inserts a bubble, enable captures, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (PCSrc) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (ifid_en) begin
      ifid_instr <= imem_rdata;
      ifid_pc4   <= w_pc_plus4;
      ifid_valid <= 1'b1;
    end
  end

  // Status state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= ST_RUN;
    end else begin
      r_status <= w_status_next;
    end
  end

  // Status next-state: redirect, then stall, else running.
  always_comb begin
    w_status_next = ST_RUN;
    if (PCSrc) begin
      w_status_next = ST_REDIRECT;
    end else if (!ifid_en) begin
      w_status_next = ST_STALL;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters; a flush edge is never also a stall edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (PCSrc) begin
      if (r_flush_cnt != 32'hFFFF_FFFF) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end else if (!ifid_en) begin
      if (r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

  // Status is observed only from debug access; alignment bits are ignored.
  logic w_unused;
  assign w_unused = &{1'b0, branch_target[1:0], r_status};

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage. A driver issues directed and
//               random controls, advances an abstract fetch model and queues
//               the expected post-edge outputs; a monitor pops and compares
//               after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic        ifid_en;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t q[$];

  // Abstract fetch model state.
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, else an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0011;
      32'h0000_0004: return 32'h0000_0022;
      32'h0000_0008: return 32'h0000_0033;
      32'h0000_0040: return 32'h0000_00AA;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_stall = 32'd0;
    m_flush = 32'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  imem_addr, RESET_PC);
    check({tag, "_instr"}, ifid_instr, NOP_INSTR);
    check({tag, "_pc4"},   ifid_pc4, 32'd0);
    check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, "_scnt"},  stall_cnt, 32'd0);
    check({tag, "_fcnt"},  flush_cnt, 32'd0);
  endtask

  // Called between edges: apply controls, step the model, queue expectation.
  task automatic cycle(input logic pe, input logic ie, input logic ps, input logic [31:0] tgt);
    exp_t e;
    pc_en         = pe;
    ifid_en       = ie;
    PCSrc         = ps;
    branch_target = tgt;
    if (ps) begin
      m_flush = sat_inc(m_flush);
      m_instr = NOP_INSTR;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      m_pc    = tgt & 32'hFFFF_FFFC;
    end else begin
      if (ie) begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end else begin
        m_stall = sat_inc(m_stall);
      end
      if (pe) m_pc = m_pc + 32'd4;
    end
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    e.scnt  = PERF ? m_stall : 32'd0;
    e.fcnt  = PERF ? m_flush : 32'd0;
    q.push_back(e);
    @(posedge clk);
    #4;
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("imem_addr",  imem_addr, e.addr);
      check("ifid_instr", ifid_instr, e.instr);
      check("ifid_pc4",   ifid_pc4, e.pc4);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      check("stall_cnt",  stall_cnt, e.scnt);
      check("flush_cnt",  flush_cnt, e.fcnt);
    end
  end

  initial begin
    logic [31:0] tgt;
    logic        ps;
    rst           = 1'b1;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    PCSrc         = 1'b0;
    branch_target = 32'd0;
    model_reset();
    #3;
    check_reset_values("reset");
    @(posedge clk);
    #4;
    rst = 1'b0;

    // Sequential fetch from reset.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    // Load-use stall at pc=8, then resume.
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    // Branch flush to 0x40 and the first target fetch.
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    // Flush while stalled, unaligned target.
    cycle(1'b0, 1'b0, 1'b1, 32'h43);
    // pc_en low with ifid_en high reloads the same word.
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Asynchronous reset right after a redirect, checked before any edge.
    cycle(1'b1, 1'b1, 1'b1, 32'h80);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #4;
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ps  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ps, tgt);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q.size() != 0; i++) begin
      @(posedge clk);
      #4;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
